databus_wsctl: RTL and testbench

- Parametrised successor to the processor's data bus driver.
- Connects the internal bus (IBUS) to the external data bus (DB) for memory and I/O cycles.
- Generates a single-cycle W# write strobe.
- Inserts programmable and external (WS#) wait states, with a timeout guard.
- Sits between the microcode-driven control unit and the backplane. Its busy flag stalls the processor while a bus cycle is in flight.

---
 rtl/databus_wsctl.sv | 78 +++++++
 tb/tb_databus_wsctl.sv | 113 +++++++++++
 2 files changed

// File: rtl/databus_wsctl.sv
// databus_wsctl: IBUS/DB bus-cycle controller with write strobe, wait states and timeout guard
module databus_wsctl #(
  parameter int WIDTH   = 16,
  parameter int WSW     = 3,
  parameter int MAXWAIT = 15
) (
  input  logic             clk4,
  input  logic             nreset,
  input  logic             nmem,
  input  logic             nio,
  input  logic             nr,
  input  logic             nwen,
  input  logic             nws,
  input  logic [WSW-1:0]   ws_prog,
  input  logic [WIDTH-1:0] ibus_in,
  output logic [WIDTH-1:0] ibus_out,
  output logic             ibus_oe,
  input  logic [WIDTH-1:0] db_in,
  output logic [WIDTH-1:0] db_out,
  output logic             db_oe,
  output logic             nw,
  output logic             busy,
  output logic             ack,
  output logic             timeout
);
  localparam int CW = ($clog2(MAXWAIT + 1) > WSW ? $clog2(MAXWAIT + 1) : WSW) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, WAIT, STROBE, HOLD} state_t;
  state_t state, nxt;
  logic is_wr, armed;
  logic [CW-1:0] cnt;
  logic req, wr_req, accept, wait_done, to_hit;
  assign req       = (!nmem || !nio) && (!nr || !nwen);
  assign wr_req    = !nr && !nwen;
  assign accept    = state == IDLE && armed && req;
  assign wait_done = (cnt + CW'(1) >= CW'(ws_prog)) && nws;
  assign to_hit    = state == WAIT && !wait_done && cnt == CW'(MAXWAIT - 1);
  always_ff @(posedge clk4)
    if (!nreset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = accept ? SETUP : IDLE;
      SETUP:   nxt = (ws_prog != '0 || !nws) ? WAIT : STROBE;
      WAIT:    nxt = wait_done ? STROBE : to_hit ? HOLD : WAIT;
      STROBE:  nxt = HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy    = state != IDLE;
    ack     = state == HOLD;
    nw      = !(state == STROBE && is_wr);
    db_oe   = busy && is_wr;
    ibus_oe = ack && !is_wr;
  end
  // armed re-arms only once both request lines are idle, so a held request
  // produces a single bus cycle
  always_ff @(posedge clk4)
    if (!nreset) begin
      is_wr    <= 1'b0;
      armed    <= 1'b1;
      cnt      <= '0;
      timeout  <= 1'b0;
      ibus_out <= '0;
      db_out   <= '0;
    end else begin
      armed <= accept ? 1'b0 : (nmem && nio) ? 1'b1 : armed;
      cnt   <= state == WAIT ? cnt + CW'(1) : '0;
      if (accept) begin
        is_wr   <= wr_req;
        timeout <= 1'b0;
        if (wr_req) db_out <= ibus_in;
      end
      if (to_hit) timeout <= 1'b1;
      if (state == STROBE && !is_wr) ibus_out <= db_in;
    end
endmodule

// File: tb/tb_databus_wsctl.sv
// tb_databus_wsctl: directed bench with a cycle-count reference model for databus_wsctl
module tb_databus_wsctl;
  localparam int MAXWAIT = 15;
  logic clk4 = 0, nreset = 0, nmem = 1, nio = 1, nr = 1, nwen = 1, nws = 1;
  logic [2:0] ws_prog = 0;
  logic [15:0] ibus_in = 0, db_in = 0, ibus_out, db_out;
  logic ibus_oe, db_oe, nw, busy, ack, timeout;
  int n_cmp = 0, n_bad = 0, pulses;
  databus_wsctl dut (
    .clk4(clk4), .nreset(nreset), .nmem(nmem), .nio(nio), .nr(nr), .nwen(nwen),
    .nws(nws), .ws_prog(ws_prog), .ibus_in(ibus_in), .ibus_out(ibus_out),
    .ibus_oe(ibus_oe), .db_in(db_in), .db_out(db_out), .db_oe(db_oe), .nw(nw),
    .busy(busy), .ack(ack), .timeout(timeout)
  );
  always #5 clk4 = ~clk4;
  // model: a cycle is described by its position since acceptance, the cycle
  // holding the strobe (sc) and the cycle holding the ack (hc)
  logic go = 0, m_act = 0, m_wr = 0, m_armed = 1, m_to = 0;
  int m_cyc = 0, m_sc = 0, m_hc = 0, m_k = 0;
  logic [15:0] m_db = 0, m_ib = 0;
  always @(posedge clk4) begin
    if (!nreset) begin
      m_act <= 0; m_armed <= 1; m_to <= 0; m_db <= 0; m_ib <= 0; m_wr <= 0; go <= 1;
    end else if (!m_act && m_armed && (!nmem || !nio) && (!nr || !nwen)) begin
      m_act <= 1; m_cyc <= 1; m_sc <= 0; m_hc <= 0; m_k <= 0; m_to <= 0; m_armed <= 0;
      m_wr <= !nr && !nwen;
      if (!nr && !nwen) m_db <= ibus_in;
    end else begin
      if (nmem && nio) m_armed <= 1;
      if (m_act) begin
        m_cyc <= m_cyc + 1;
        if (m_cyc == m_hc) m_act <= 0;
        else if (m_cyc == m_sc) begin
          m_hc <= m_cyc + 1;
          if (!m_wr) m_ib <= db_in;
        end else if (m_cyc == 1) begin
          if (ws_prog == 0 && nws) m_sc <= 2;
        end else if (m_k + 1 >= int'(ws_prog) && nws) m_sc <= m_cyc + 1;
        else if (m_k == MAXWAIT - 1) begin
          m_hc <= m_cyc + 1;
          m_to <= 1;
        end else m_k <= m_k + 1;
      end
    end
  end
  logic [36:0] exp_v, act_v;
  always @(negedge clk4) if (go) begin
    exp_v = {m_ib, m_db, m_act && m_cyc == m_hc && !m_wr, m_act && m_wr,
             !(m_act && m_wr && m_cyc == m_sc), m_act, m_act && m_cyc == m_hc, m_to};
    act_v = {ibus_out, db_out, ibus_oe, db_oe, nw, busy, ack, timeout};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model t=%0t got %h want %h", $time, act_v, exp_v);
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic tick;
    @(posedge clk4);
    #1;
  endtask
  task automatic idle_req;
    nmem = 1; nio = 1; nr = 1; nwen = 1;
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_busy", busy, 0); chk("rst_nw", nw, 1); chk("rst_dboe", db_oe, 0);
    chk("rst_ibus_out", ibus_out, 0); chk("rst_to", timeout, 0);
    nreset = 1; tick;
    // zero-wait write
    nmem = 0; nr = 0; nwen = 0; ibus_in = 16'hA5C3; tick; idle_req;
    chk("t1_dboe_c1", db_oe, 1); chk("t1_nw_c1", nw, 1);
    tick; chk("t1_nw_c2", nw, 0); chk("t1_dbout", db_out, 16'hA5C3);
    tick; chk("t1_ack_c3", ack, 1); chk("t1_dboe_c3", db_oe, 1);
    tick; chk("t1_busy_c4", busy, 0);
    // three programmed waits on a read: strobe cycle 5, ack cycle 6
    ws_prog = 3; db_in = 16'h1234; nio = 0; nr = 0; tick; idle_req;
    repeat (4) tick; chk("t2_ack_c5", ack, 0);
    tick; chk("t2_ack_c6", ack, 1); chk("t2_iboe", ibus_oe, 1);
    chk("t2_ibus_out", ibus_out, 16'h1234); chk("t2_dboe", db_oe, 0);
    tick; chk("t2_busy_c7", busy, 0);
    // external waits hold off the strobe
    ws_prog = 1; ibus_in = 16'h5A5A; nmem = 0; nr = 0; nwen = 0; tick; idle_req;
    nws = 0; repeat (5) tick; chk("t3_nw_c6", nw, 1);
    nws = 1; tick; chk("t3_nw_c7", nw, 0);
    tick; chk("t3_ack_c8", ack, 1); tick;
    // timeout after MAXWAIT wait cycles
    ws_prog = 0; nmem = 0; nr = 0; tick; idle_req;
    nws = 0; repeat (16) tick; chk("t4_ack", ack, 1); chk("t4_to", timeout, 1);
    nws = 1; tick; chk("t4_busy", busy, 0); chk("t4_to_sticky", timeout, 1);
    // held request yields one cycle
    nmem = 0; nr = 0; nwen = 0; ibus_in = 16'hC0DE; pulses = 0;
    repeat (20) begin tick; if (!nw) pulses++; end
    chk("t5_pulses", pulses, 1); chk("t5_to_clr", timeout, 0);
    nmem = 1; tick; nmem = 0; tick; chk("t5_retrig", busy, 1);
    idle_req; repeat (4) tick;
    // reset in the middle of a WAIT
    ws_prog = 5; ibus_in = 16'h0F0F; nmem = 0; nr = 0; nwen = 0; tick; idle_req;
    repeat (3) tick; chk("t6_busy_pre", busy, 1);
    nreset = 0; tick; chk("t6_busy", busy, 0); chk("t6_nw", nw, 1); chk("t6_dboe", db_oe, 0);
    nreset = 1; pulses = 0;
    repeat (10) begin tick; if (!nw) pulses++; end
    chk("t6_pulses", pulses, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
